// File: rtl/ofm_write_packer.sv
`default_nettype none
// ============================================================================
// Module : ofm_write_packer
// Desc   : Queues packed OFM result vectors and issues masked RAM writes, with
//          optional 2x2 nearest-neighbour upsample expansion.
//          Define OFM_WR_STATS_EN to enable the request/write counters.
// Rev    : 1.0  initial release
// ============================================================================
module ofm_write_packer #(
    parameter int DATA_WIDTH   = 16,
    parameter int INOUT_WIDTH  = 256,
    parameter int OFM_RAM_SIZE = 2378675,
    parameter int FIFO_DEPTH   = 4,
    localparam int c_lanes = INOUT_WIDTH / DATA_WIDTH,
    localparam int c_aw    = $clog2(OFM_RAM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [c_aw-1:0]        in_addr,
    input  logic [INOUT_WIDTH-1:0] in_data,
    input  logic [4:0]             in_size,
    input  logic                   upsample_mode,
    input  logic [8:0]             ofm_size,
    output logic                   ram_we,
    output logic [c_aw-1:0]        ram_addr,
    output logic [INOUT_WIDTH-1:0] ram_data,
    output logic [c_lanes-1:0]     ram_mask,
    output logic                   busy,
    output logic                   addr_err,
    output logic [31:0]            stat_req_cnt,
    output logic [31:0]            stat_wr_cnt
);

    localparam int c_nw   = $clog2(c_lanes + 1);
    localparam int c_half = c_lanes / 2;
    localparam int c_pw   = $clog2(FIFO_DEPTH);
    localparam int c_cw   = c_pw + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_R0LO = 3'd1,
        S_R0HI = 3'd2,
        S_R1LO = 3'd3,
        S_R1HI = 3'd4
    } state_t;

    state_t r_state;

    logic [c_aw-1:0]        r_fifo_addr [FIFO_DEPTH];
    logic [INOUT_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [c_nw-1:0]        r_fifo_n    [FIFO_DEPTH];
    logic                   r_fifo_up   [FIFO_DEPTH];
    logic [8:0]             r_fifo_ofm  [FIFO_DEPTH];
    logic [c_pw-1:0]        r_wr_ptr;
    logic [c_pw-1:0]        r_rd_ptr;
    logic [c_cw-1:0]        r_count;

    logic                   r_in_ready;
    logic                   r_busy;
    logic                   r_ram_we;
    logic [c_aw-1:0]        r_ram_addr;
    logic [INOUT_WIDTH-1:0] r_ram_data;
    logic [c_lanes-1:0]     r_ram_mask;
    logic                   r_addr_err;

    logic                   w_push;
    logic                   w_pop;
    logic [c_cw-1:0]        w_count_next;
    logic [c_nw-1:0]        w_in_n;
    logic [c_aw-1:0]        w_head_addr;
    logic [INOUT_WIDTH-1:0] w_head_data;
    logic [c_nw-1:0]        w_head_n;
    logic                   w_head_up;
    logic [8:0]             w_head_ofm;
    logic                   w_wr_state;
    logic                   w_hi;
    logic                   w_row1;
    logic [c_aw-1:0]        w_base;
    logic [INOUT_WIDTH-1:0] w_lane_data;
    logic [c_lanes-1:0]     w_req_mask;
    logic [c_lanes-1:0]     w_oob;
    logic [c_lanes-1:0]     w_fin_mask;
    int                     w_idx;

    assign w_push       = in_valid && r_in_ready;
    assign w_count_next = r_count + c_cw'(w_push) - c_cw'(w_pop);
    assign w_in_n       = (in_size > 5'(c_lanes)) ? c_nw'(c_lanes) : c_nw'(in_size);

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_n    = r_fifo_n[r_rd_ptr];
    assign w_head_up   = r_fifo_up[r_rd_ptr];
    assign w_head_ofm  = r_fifo_ofm[r_rd_ptr];

    // A head entry stays queued until its final write so that a full FIFO
    // really holds FIFO_DEPTH outstanding requests.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = (r_count != '0) && (w_head_n == '0);
            S_R0LO:  w_pop = !w_head_up;
            S_R1LO:  w_pop = (w_head_n <= c_nw'(c_half));
            S_R1HI:  w_pop = 1'b1;
            default: w_pop = 1'b0;
        endcase
    end

    assign w_wr_state = (r_state != S_IDLE);
    assign w_hi       = (r_state == S_R0HI) || (r_state == S_R1HI);
    assign w_row1     = (r_state == S_R1LO) || (r_state == S_R1HI);
    assign w_base     = w_head_addr + (w_hi ? c_aw'(c_lanes) : '0)
                                    + (w_row1 ? c_aw'(w_head_ofm) : '0);

    // Output lane k carries source element w_idx; in upsample mode each
    // element is duplicated into an adjacent lane pair.
    always_comb begin
        w_lane_data = '0;
        w_req_mask  = '0;
        w_oob       = '0;
        w_idx       = 0;
        for (int k = 0; k < c_lanes; k++) begin
            w_idx = w_head_up ? ((w_hi ? c_half : 0) + k / 2) : k;
            w_lane_data[k*DATA_WIDTH +: DATA_WIDTH] = w_head_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
            w_req_mask[k] = (c_nw'(w_idx) < w_head_n);
            w_oob[k]      = ({1'b0, w_base + c_aw'(k)} >= (c_aw + 1)'(OFM_RAM_SIZE));
        end
    end

    assign w_fin_mask = w_req_mask & ~w_oob;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_mask <= '0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= in_addr;
                r_fifo_data[r_wr_ptr] <= in_data;
                r_fifo_n[r_wr_ptr]    <= w_in_n;
                r_fifo_up[r_wr_ptr]   <= upsample_mode;
                r_fifo_ofm[r_wr_ptr]  <= ofm_size;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != c_cw'(FIFO_DEPTH));
            r_busy     <= (w_count_next != '0) || w_wr_state;
            r_ram_we   <= w_wr_state && (|w_fin_mask);
            if (w_wr_state) begin
                r_ram_addr <= w_base;
                r_ram_data <= w_lane_data;
                r_ram_mask <= w_fin_mask;
                if (|(w_req_mask & w_oob)) begin
                    r_addr_err <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= (w_head_n == '0) ? S_IDLE : S_R0LO;
                    end
                end
                S_R0LO: begin
                    if (!w_head_up) begin
                        r_state <= S_IDLE;
                    end else if (w_head_n > c_nw'(c_half)) begin
                        r_state <= S_R0HI;
                    end else begin
                        r_state <= S_R1LO;
                    end
                end
                S_R0HI:  r_state <= S_R1LO;
                S_R1LO:  r_state <= (w_head_n > c_nw'(c_half)) ? S_R1HI : S_IDLE;
                S_R1HI:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_data = r_ram_data;
    assign ram_mask = r_ram_mask;
    assign addr_err = r_addr_err;

`ifdef OFM_WR_STATS_EN
    logic [31:0] r_stat_req;
    logic [31:0] r_stat_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_req <= '0;
            r_stat_wr  <= '0;
        end else begin
            if (w_push) begin
                r_stat_req <= r_stat_req + 32'd1;
            end
            if (w_wr_state && (|w_fin_mask)) begin
                r_stat_wr <= r_stat_wr + 32'd1;
            end
        end
    end

    assign stat_req_cnt = r_stat_req;
    assign stat_wr_cnt  = r_stat_wr;
`else
    assign stat_req_cnt = '0;
    assign stat_wr_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofm_write_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_ofm_write_packer
// Desc   : Directed self-checking bench for ofm_write_packer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ofm_write_packer;

    localparam int DW    = 16;
    localparam int IW    = 256;
    localparam int L     = 16;
    localparam int RAM   = 2378675;
    localparam int AW    = $clog2(RAM);
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [IW-1:0] in_data;
    logic [4:0]    in_size;
    logic          upsample_mode;
    logic [8:0]    ofm_size;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [IW-1:0] ram_data;
    logic [L-1:0]  ram_mask;
    logic          busy;
    logic          addr_err;
    logic [31:0]   stat_req_cnt;
    logic [31:0]   stat_wr_cnt;

    ofm_write_packer #(
        .DATA_WIDTH  (DW),
        .INOUT_WIDTH (IW),
        .OFM_RAM_SIZE(RAM),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_size      (in_size),
        .upsample_mode(upsample_mode),
        .ofm_size     (ofm_size),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_mask     (ram_mask),
        .busy         (busy),
        .addr_err     (addr_err),
        .stat_req_cnt (stat_req_cnt),
        .stat_wr_cnt  (stat_wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] data;
        logic [L-1:0]  mask;
    } wr_t;

    wr_t wr_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wr_t w;
            w.addr = ram_addr;
            w.data = ram_data;
            w.mask = ram_mask;
            wr_q.push_back(w);
            check("we_mask_nonzero", IW'(ram_mask == '0), '0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] ramp(input int base);
        logic [IW-1:0] v;
        v = '0;
        for (int j = 0; j < L; j++) v[j*DW +: DW] = DW'(base + j);
        return v;
    endfunction

    function automatic logic [IW-1:0] expand(input logic [IW-1:0] src, input int hi);
        logic [IW-1:0] v;
        v = '0;
        for (int k = 0; k < L; k++) v[k*DW +: DW] = src[(hi*8 + k/2)*DW +: DW];
        return v;
    endfunction

    function automatic logic [IW-1:0] lanes(input logic [L-1:0] m);
        logic [IW-1:0] v;
        v = '0;
        for (int k = 0; k < L; k++) v[k*DW +: DW] = {DW{m[k]}};
        return v;
    endfunction

    // Leaves in_valid high so consecutive calls drive back-to-back requests.
    task automatic send(input logic [AW-1:0] a, input logic [IW-1:0] d, input logic [4:0] sz,
                        input logic up, input logic [8:0] ofm);
        int guard;
        guard = 0;
        in_addr = a; in_data = d; in_size = sz; upsample_mode = up; ofm_size = ofm;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("send_timeout", 1, 0);
        tick();
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        in_valid = 1'b0;
        while (busy !== 1'b0 && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) check("idle_timeout", 1, 0);
        tick();
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [AW-1:0] a,
                            input logic [IW-1:0] d, input logic [L-1:0] m);
        if (idx < wr_q.size()) begin
            check({tag, "_addr"}, IW'(wr_q[idx].addr), IW'(a));
            check({tag, "_mask"}, IW'(wr_q[idx].mask), IW'(m));
            check({tag, "_data"}, wr_q[idx].data & lanes(m), d & lanes(m));
        end else begin
            check({tag, "_missing"}, 0, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0]   req0, wr0;
        logic [IW-1:0] src;
        int            guard;

        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
        in_size = '0; upsample_mode = 1'b0; ofm_size = '0;
        repeat (3) tick();
        check("rst_in_ready", IW'(in_ready), 0);
        check("rst_ram_we",   IW'(ram_we),   0);
        check("rst_ram_addr", IW'(ram_addr), 0);
        check("rst_ram_data", ram_data,      0);
        check("rst_ram_mask", IW'(ram_mask), 0);
        check("rst_busy",     IW'(busy),     0);
        check("rst_addr_err", IW'(addr_err), 0);
        check("rst_stat_req", IW'(stat_req_cnt), 0);
        check("rst_stat_wr",  IW'(stat_wr_cnt),  0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", IW'(in_ready), 1);

        // Normal N=16 with cycle-exact latency
        wr_q.delete();
        send(AW'(100), ramp(0), 5'd16, 1'b0, 9'd0);
        in_valid = 1'b0;
        check("lat_c0_we", IW'(ram_we), 0);
        tick();
        check("lat_c1_we", IW'(ram_we), 0);
        check("lat_c1_busy", IW'(busy), 1);
        tick();
        check("n16_we",   IW'(ram_we),   1);
        check("n16_addr", IW'(ram_addr), 100);
        check("n16_mask", IW'(ram_mask), 16'hFFFF);
        check("n16_data", ram_data, ramp(0));
        check("n16_busy", IW'(busy), 1);
        tick();
        check("n16_busy_fall", IW'(busy), 0);
        check("n16_we_fall",   IW'(ram_we), 0);
        check("n16_count", wr_q.size(), 1);

        // Normal N=5
        wr_q.delete();
        send(AW'(200), ramp(32), 5'd5, 1'b0, 9'd0);
        wait_idle();
        check("n5_count", wr_q.size(), 1);
        check_wr("n5", 0, AW'(200), ramp(32), 16'h001F);

        // Size 0 consumes the request without writing
        req0 = stat_req_cnt; wr0 = stat_wr_cnt;
        wr_q.delete();
        send(AW'(300), ramp(0), 5'd0, 1'b0, 9'd0);
        wait_idle();
        check("n0_count", wr_q.size(), 0);
`ifdef OFM_WR_STATS_EN
        check("n0_stat_req", IW'(stat_req_cnt), IW'(req0 + 32'd1));
        check("n0_stat_wr",  IW'(stat_wr_cnt),  IW'(wr0));
`else
        check("n0_stat_req", IW'(stat_req_cnt), 0);
        check("n0_stat_wr",  IW'(stat_wr_cnt),  0);
`endif

        // Oversize clamps to 16 lanes
        wr_q.delete();
        send(AW'(400), ramp(64), 5'd20, 1'b0, 9'd0);
        wait_idle();
        check("n20_count", wr_q.size(), 1);
        check_wr("n20", 0, AW'(400), ramp(64), 16'hFFFF);

        // Upsample N=12, four writes
        wr_q.delete();
        src = ramp(0);
        send(AW'(0), src, 5'd12, 1'b1, 9'd52);
        wait_idle();
        check("up12_count", wr_q.size(), 4);
        check_wr("up12_w0", 0, AW'(0),  expand(src, 0), 16'hFFFF);
        check_wr("up12_w1", 1, AW'(16), expand(src, 1), 16'h00FF);
        check_wr("up12_w2", 2, AW'(52), expand(src, 0), 16'hFFFF);
        check_wr("up12_w3", 3, AW'(68), expand(src, 1), 16'h00FF);

        // Upsample N=4, only the low halves
        wr_q.delete();
        src = ramp(100);
        send(AW'(500), src, 5'd4, 1'b1, 9'd20);
        wait_idle();
        check("up4_count", wr_q.size(), 2);
        check_wr("up4_w0", 0, AW'(500), expand(src, 0), 16'h00FF);
        check_wr("up4_w1", 1, AW'(520), expand(src, 0), 16'h00FF);

        // FIFO full with 10 back-to-back upsample N=16 requests
        wr_q.delete();
        for (int r = 0; r < 10; r++) begin
            send(AW'(r * 256), ramp(r * 16), 5'd16, 1'b1, 9'd52);
            if (r == 3) check("full_ready_low", IW'(in_ready), 0);
        end
        wait_idle();
        check("full_count", wr_q.size(), 40);
        for (int r = 0; r < 10; r++) begin
            for (int w = 0; w < 4; w++) begin
                check_wr($sformatf("full_r%0d_w%0d", r, w), r * 4 + w,
                         AW'(r * 256 + ((w % 2) ? 16 : 0) + ((w / 2) ? 52 : 0)),
                         expand(ramp(r * 16), w % 2), 16'hFFFF);
            end
        end

        // Out-of-range lanes are masked and flagged
        wr_q.delete();
        send(AW'(RAM - 4), ramp(0), 5'd16, 1'b0, 9'd0);
        wait_idle();
        check("oob_count", wr_q.size(), 1);
        check_wr("oob", 0, AW'(RAM - 4), ramp(0), 16'h000F);
        check("oob_err", IW'(addr_err), 1);
        send(AW'(10), ramp(0), 5'd16, 1'b0, 9'd0);
        wait_idle();
        check("oob_err_sticky", IW'(addr_err), 1);

        // Reset while the sequencer is in R1LO with more requests queued
        wr_q.delete();
        send(AW'(1000), ramp(0), 5'd4, 1'b1, 9'd52);
        send(AW'(2000), ramp(16), 5'd4, 1'b1, 9'd52);
        send(AW'(3000), ramp(32), 5'd4, 1'b1, 9'd52);
        in_valid = 1'b0;
        guard = 0;
        while (!(ram_we === 1'b1 && ram_addr == AW'(1000)) && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("r1lo_timeout", 1, 0);
        rst = 1'b1;
        tick();
        check("mid_rst_we",    IW'(ram_we),   0);
        check("mid_rst_busy",  IW'(busy),     0);
        check("mid_rst_ready", IW'(in_ready), 0);
        check("mid_rst_err",   IW'(addr_err), 0);
        rst = 1'b0;
        wr_q.delete();
        repeat (20) tick();
        check("mid_rst_no_replay", wr_q.size(), 0);
        check("mid_rst_idle",      IW'(busy), 0);
        check("mid_rst_ready_up",  IW'(in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
